// File: rtl/ahb_op_sequencer_pkg.sv
// Shared encodings for the AHB operation sequencer: bus codes, slave register map and FSM states.
package ahb_op_sequencer_pkg;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam logic [2:0] HsizeWord    = 3'b010;
  localparam logic [2:0] HburstSingle = 3'b000;

  localparam logic [1:0] HrespOkay  = 2'b00;
  localparam logic [1:0] HrespError = 2'b01;

  localparam logic [31:0] AluBaseDefault = 32'h4000_0000;
  localparam logic [31:0] MulBaseDefault = 32'h4000_1000;

  localparam logic [31:0] OffOpa    = 32'h0000_0000;
  localparam logic [31:0] OffOpb    = 32'h0000_0004;
  localparam logic [31:0] OffCtrl   = 32'h0000_0008;
  localparam logic [31:0] OffStatus = 32'h0000_000C;
  localparam logic [31:0] OffResult = 32'h0000_0010;

  localparam int unsigned CtrlStartBit  = 0;
  localparam int unsigned CtrlOpLsb     = 1;
  localparam int unsigned StatusDoneBit = 0;

  typedef enum logic [1:0] {StIdle, StRun, StResp} seq_state_e;
  typedef enum logic [1:0] {XfIdle, XfAddr, XfData} xfer_state_e;
  typedef enum logic [2:0] {StepOpa, StepOpb, StepCtrl, StepStatus, StepResult} step_e;

  function automatic logic [31:0] step_offset(step_e s);
    logic [31:0] off;
    case (s)
      StepOpa:    off = OffOpa;
      StepOpb:    off = OffOpb;
      StepCtrl:   off = OffCtrl;
      StepStatus: off = OffStatus;
      default:    off = OffResult;
    endcase
    return off;
  endfunction

  function automatic logic step_is_write(step_e s);
    return (s == StepOpa) || (s == StepOpb) || (s == StepCtrl);
  endfunction

  function automatic logic [31:0] ctrl_word(logic [3:0] op);
    logic [31:0] w;
    w = '0;
    w[CtrlOpLsb +: 4] = op;
    w[CtrlStartBit]   = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/ahb_single_xfer.sv
// Address/data phase engine for one single-word AHB-Lite transfer; reports completion,
// error and read data combinationally in the completing data-phase cycle.
module ahb_single_xfer
  import ahb_op_sequencer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic        write_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] haddr_o,
  output logic [31:0] hwdata_o,
  output logic        hwrite_o,
  output logic [1:0]  htrans_o,
  input  logic [31:0] hrdata_i,
  input  logic [1:0]  hresp_i,
  input  logic        hready_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o
);

  xfer_state_e state_q;
  logic [31:0] haddr_q;
  logic [31:0] hwdata_q;
  logic [31:0] wdata_q;
  logic        hwrite_q;
  logic [1:0]  htrans_q;
  logic        launch;

  assign done_o  = (state_q == XfData) && hready_i;
  assign err_o   = done_o && (hresp_i == HrespError);
  assign rdata_o = hrdata_i;

  // A new transfer may start from idle or back-to-back with the completing data phase.
  assign launch = start_i && ((state_q == XfIdle) || done_o);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= XfIdle;
      haddr_q  <= '0;
      hwdata_q <= '0;
      wdata_q  <= '0;
      hwrite_q <= 1'b0;
      htrans_q <= HtransIdle;
    end else if (launch) begin
      state_q  <= XfAddr;
      haddr_q  <= addr_i;
      hwrite_q <= write_i;
      wdata_q  <= wdata_i;
      htrans_q <= HtransNonseq;
    end else begin
      case (state_q)
        XfAddr: begin
          if (hready_i) begin
            state_q  <= XfData;
            htrans_q <= HtransIdle;
            if (hwrite_q) hwdata_q <= wdata_q;
          end
        end
        XfData: begin
          if (hready_i) state_q <= XfIdle;
        end
        default: state_q <= XfIdle;
      endcase
    end
  end

  assign haddr_o  = haddr_q;
  assign hwdata_o = hwdata_q;
  assign hwrite_o = hwrite_q;
  assign htrans_o = htrans_q;

endmodule

// File: rtl/ahb_op_sequencer.sv
// AHB-Lite master that runs write OPA/OPB/CTRL, polls STATUS and reads RESULT on the ALU or
// multiplier slave, returning the result on a valid/ready response channel.
module ahb_op_sequencer
  import ahb_op_sequencer_pkg::*;
#(
  parameter logic [31:0] ALU_BASE = AluBaseDefault,
  parameter logic [31:0] MUL_BASE = MulBaseDefault,
  parameter int unsigned MAX_POLL = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_sel,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] o_HADDR,
  output logic [31:0] o_HWDATA,
  output logic        o_HWRITE,
  output logic [2:0]  o_HSIZE,
  output logic [2:0]  o_HBURST,
  output logic [1:0]  o_HTRANS,
  input  logic [31:0] i_HRDATA,
  input  logic [1:0]  i_HRESP,
  input  logic        i_HREADY
);

  localparam int unsigned PollW = $clog2(MAX_POLL + 1);

  seq_state_e       state_q, state_d;
  step_e            step_q, step_d;
  logic [PollW-1:0] poll_q, poll_d, poll_inc;
  logic [31:0]      base_q, a_q, b_q;
  logic [3:0]       op_q;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic        xf_start, xf_write, xf_done, xf_err;
  step_e       xf_step;
  logic [31:0] xf_addr, xf_wdata, xf_rdata;
  logic [31:0] cur_base, cur_a, cur_b;
  logic [3:0]  cur_op;
  logic        fin, fin_err;
  logic        accept;

  assign accept = (state_q == StIdle) && req_valid;

  // The first transfer issues on the acceptance edge, before the request is captured.
  always_comb begin
    if (state_q == StIdle) begin
      cur_base = req_sel ? MUL_BASE : ALU_BASE;
      cur_a    = req_a;
      cur_b    = req_b;
      cur_op   = req_op;
    end else begin
      cur_base = base_q;
      cur_a    = a_q;
      cur_b    = b_q;
      cur_op   = op_q;
    end
  end

  always_comb begin
    xf_addr  = cur_base + step_offset(xf_step);
    xf_write = step_is_write(xf_step);
    case (xf_step)
      StepOpa:  xf_wdata = cur_a;
      StepOpb:  xf_wdata = cur_b;
      StepCtrl: xf_wdata = ctrl_word(cur_op);
      default:  xf_wdata = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    poll_d      = poll_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    xf_start    = 1'b0;
    xf_step     = step_q;
    fin         = 1'b0;
    fin_err     = 1'b0;
    poll_inc    = poll_q + PollW'(1);
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d     = StRun;
          poll_d      = '0;
          req_ready_d = 1'b0;
          xf_start    = 1'b1;
          xf_step     = StepOpa;
        end
      end
      StRun: begin
        if (xf_done) begin
          if (xf_err) begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            case (step_q)
              StepOpa:  begin xf_start = 1'b1; xf_step = StepOpb;    end
              StepOpb:  begin xf_start = 1'b1; xf_step = StepCtrl;   end
              StepCtrl: begin xf_start = 1'b1; xf_step = StepStatus; end
              StepStatus: begin
                poll_d = poll_inc;
                if (xf_rdata[StatusDoneBit]) begin
                  xf_start = 1'b1;
                  xf_step  = StepResult;
                end else if (32'(poll_inc) >= MAX_POLL) begin
                  fin     = 1'b1;
                  fin_err = 1'b1;
                end else begin
                  xf_start = 1'b1;
                  xf_step  = StepStatus;
                end
              end
              StepResult: fin = 1'b1;
              default: begin
                fin     = 1'b1;
                fin_err = 1'b1;
              end
            endcase
          end
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (xf_start) step_d = xf_step;
    if (fin) begin
      state_d     = StResp;
      rsp_valid_d = 1'b1;
      rsp_err_d   = fin_err;
      rsp_data_d  = fin_err ? 32'h0 : xf_rdata;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      step_q      <= StepOpa;
      poll_q      <= '0;
      base_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      poll_q      <= poll_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      if (accept) begin
        base_q <= cur_base;
        a_q    <= req_a;
        b_q    <= req_b;
        op_q   <= req_op;
      end
    end
  end

  ahb_single_xfer u_xfer (
    .clk_i    (HCLK),
    .rst_ni   (HRESETn),
    .start_i  (xf_start),
    .addr_i   (xf_addr),
    .write_i  (xf_write),
    .wdata_i  (xf_wdata),
    .haddr_o  (o_HADDR),
    .hwdata_o (o_HWDATA),
    .hwrite_o (o_HWRITE),
    .htrans_o (o_HTRANS),
    .hrdata_i (i_HRDATA),
    .hresp_i  (i_HRESP),
    .hready_i (i_HREADY),
    .done_o   (xf_done),
    .err_o    (xf_err),
    .rdata_o  (xf_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign o_HSIZE   = HsizeWord;
  assign o_HBURST  = HburstSingle;

endmodule

// File: tb/tb_ahb_op_sequencer.sv
// Directed bench for ahb_op_sequencer with a small behavioural ALU/multiplier slave model.
module tb_ahb_op_sequencer;

  localparam logic [31:0] AluB = 32'h2000_0000;
  localparam logic [31:0] MulB = 32'h3000_0100;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req_valid, req_ready, req_sel;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] o_HADDR, o_HWDATA, i_HRDATA;
  logic        o_HWRITE, i_HREADY;
  logic [2:0]  o_HSIZE, o_HBURST;
  logic [1:0]  o_HTRANS, i_HRESP;

  ahb_op_sequencer #(
    .ALU_BASE (AluB),
    .MUL_BASE (MulB),
    .MAX_POLL (4)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .o_HADDR   (o_HADDR),
    .o_HWDATA  (o_HWDATA),
    .o_HWRITE  (o_HWRITE),
    .o_HSIZE   (o_HSIZE),
    .o_HBURST  (o_HBURST),
    .o_HTRANS  (o_HTRANS),
    .i_HRDATA  (i_HRDATA),
    .i_HRESP   (i_HRESP),
    .i_HREADY  (i_HREADY)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave configuration and observation log.
  logic [31:0] sl_wait_addr = 32'hFFFF_FFFF;
  int          sl_wait_n    = 0;
  logic [31:0] sl_err_addr  = 32'hFFFF_FFFF;
  int          sl_polls     = 1;
  logic [31:0] sl_result    = 32'h0;
  int          sl_phase     = 0;
  int          n_status, n_result, n_proto;
  int          acc_base;
  logic [31:0] log_addr[$];
  logic        log_wr[$];
  int          log_cyc[$];
  logic [31:0] log_wdata[$];

  initial begin
    int  waits;
    bit  err_pend, err_first;
    logic [31:0] cur_addr;
    logic        cur_write;
    i_HREADY = 1'b1;
    i_HRESP  = 2'b00;
    i_HRDATA = 32'h0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        sl_phase = 0;
        i_HREADY = 1'b1;
        i_HRESP  = 2'b00;
      end else if (sl_phase == 0) begin
        i_HREADY = 1'b1;
        i_HRESP  = 2'b00;
        if (o_HTRANS == 2'b10) begin
          log_addr.push_back(o_HADDR);
          log_wr.push_back(o_HWRITE);
          log_cyc.push_back(cyc - acc_base);
          cur_addr  = o_HADDR;
          cur_write = o_HWRITE;
          waits     = (o_HADDR == sl_wait_addr) ? sl_wait_n : 0;
          err_pend  = (o_HADDR == sl_err_addr);
          err_first = 1'b0;
          sl_phase  = 1;
        end
      end else begin
        if (o_HTRANS != 2'b00) n_proto++;
        if (waits > 0) begin
          waits--;
          i_HREADY = 1'b0;
          i_HRESP  = 2'b00;
        end else if (err_pend && !err_first) begin
          err_first = 1'b1;
          i_HREADY  = 1'b0;
          i_HRESP   = 2'b01;
        end else begin
          i_HREADY = 1'b1;
          i_HRESP  = err_pend ? 2'b01 : 2'b00;
          i_HRDATA = 32'h0;
          if (!err_pend && !cur_write) begin
            if (cur_addr[7:0] == 8'h0C || cur_addr[7:0] == 8'h0C + 8'h00) begin
              n_status++;
              i_HRDATA = {31'b0, (n_status >= sl_polls)};
            end
            if (cur_addr[7:0] == 8'h10) begin
              n_result++;
              i_HRDATA = sl_result;
            end
          end
          if (cur_write) log_wdata.push_back(o_HWDATA);
          sl_phase = 0;
        end
      end
    end
  end

  task automatic do_req(input logic sel, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    log_addr.delete();
    log_wr.delete();
    log_cyc.delete();
    log_wdata.delete();
    n_status = 0;
    n_result = 0;
    n_proto  = 0;
    check_eq("req_ready_idle", 32'(req_ready), 32'h1);
    req_sel   = sel;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    acc_base  = cyc;
    @(negedge HCLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int seen);
    seen = -1;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid) begin
        seen = cyc - acc_base;
        break;
      end
      @(negedge HCLK);
    end
    if (seen < 0) check_eq("rsp_timeout", 32'h0, 32'h1);
  endtask

  task automatic take_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge HCLK);
    rsp_ready = 1'b0;
    check_eq({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 32'h0);
    check_eq({tag, "_req_ready_back"}, 32'(req_ready), 32'h1);
  endtask

  // Expected order: OPA, OPB, CTRL writes, then n_polls STATUS reads, then optional RESULT.
  task automatic check_xfers(input string tag, input logic [31:0] base, input int n_polls,
                             input bit has_result, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input bit zero_wait);
    int total;
    logic [31:0] off, wexp;
    total = 3 + n_polls + (has_result ? 1 : 0);
    check_eq({tag, "_n_xfer"}, 32'(log_addr.size()), 32'(total));
    for (int i = 0; i < total; i++) begin
      if (i < 3) off = 32'(i * 4);
      else if (i < 3 + n_polls) off = 32'h0C;
      else off = 32'h10;
      if (i < log_addr.size()) begin
        check_eq($sformatf("%s_addr%0d", tag, i), log_addr[i], base + off);
        check_eq($sformatf("%s_wr%0d", tag, i), 32'(log_wr[i]), 32'(i < 3));
        if (zero_wait) check_eq($sformatf("%s_cyc%0d", tag, i), 32'(log_cyc[i]), 32'(2 * i + 1));
      end
    end
    check_eq({tag, "_n_wdata"}, 32'(log_wdata.size()), 32'h3);
    for (int i = 0; i < 3; i++) begin
      wexp = (i == 0) ? w0 : (i == 1) ? w1 : w2;
      if (i < log_wdata.size()) check_eq($sformatf("%s_wdata%0d", tag, i), log_wdata[i], wexp);
    end
    check_eq({tag, "_htrans_idle_in_data"}, 32'(n_proto), 32'h0);
  endtask

  initial begin
    int c;
    int hits;
    HRESETn   = 1'b0;
    req_valid = 1'b0;
    req_sel   = 1'b0;
    req_op    = 4'h0;
    req_a     = 32'h0;
    req_b     = 32'h0;
    rsp_ready = 1'b0;
    acc_base  = 0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check_eq("rst_req_ready", 32'(req_ready), 32'h1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rsp_data", rsp_data, 32'h0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'h0);
    check_eq("rst_htrans", 32'(o_HTRANS), 32'h0);
    check_eq("rst_haddr", o_HADDR, 32'h0);
    check_eq("rst_hwdata", o_HWDATA, 32'h0);
    check_eq("rst_hwrite", 32'(o_HWRITE), 32'h0);
    check_eq("rst_hsize", 32'(o_HSIZE), 32'h2);
    check_eq("rst_hburst", 32'(o_HBURST), 32'h0);

    // T1: multiplier 6*7, zero-wait, done on first poll.
    sl_polls = 1; sl_result = 32'd42;
    do_req(1'b1, 4'd0, 32'd6, 32'd7);
    wait_rsp(c);
    check_eq("t1_rsp_cycle", 32'(c), 32'd11);
    check_eq("t1_rsp_data", rsp_data, 32'd42);
    check_eq("t1_rsp_err", 32'(rsp_err), 32'h0);
    check_xfers("t1", MulB, 1, 1'b1, 32'd6, 32'd7, 32'h1, 1'b1);
    take_rsp("t1");

    // T2: ALU op 3, two wait states on the OPB write, done on third poll.
    sl_polls = 3; sl_result = 32'h0000_0204; sl_wait_addr = AluB + 32'h4; sl_wait_n = 2;
    do_req(1'b0, 4'd3, 32'h1234, 32'h0F0F);
    wait_rsp(c);
    check_eq("t2_rsp_cycle", 32'(c), 32'd17);
    check_eq("t2_rsp_data", rsp_data, 32'h0000_0204);
    check_eq("t2_rsp_err", 32'(rsp_err), 32'h0);
    check_eq("t2_n_status", 32'(n_status), 32'd3);
    check_eq("t2_n_result", 32'(n_result), 32'd1);
    check_xfers("t2", AluB, 3, 1'b1, 32'h1234, 32'h0F0F, 32'h7, 1'b0);
    take_rsp("t2");
    sl_wait_addr = 32'hFFFF_FFFF; sl_wait_n = 0;

    // T3: status never done, poll limit 4.
    sl_polls = 1000; sl_result = 32'hDEAD_BEEF;
    do_req(1'b0, 4'd1, 32'd1, 32'd2);
    wait_rsp(c);
    check_eq("t3_rsp_cycle", 32'(c), 32'd15);
    check_eq("t3_rsp_data", rsp_data, 32'h0);
    check_eq("t3_rsp_err", 32'(rsp_err), 32'h1);
    check_eq("t3_n_status", 32'(n_status), 32'd4);
    check_eq("t3_n_result", 32'(n_result), 32'd0);
    check_xfers("t3", AluB, 4, 1'b0, 32'd1, 32'd2, 32'h3, 1'b1);
    take_rsp("t3");

    // T4: ERROR on the CTRL write, response held for five cycles.
    sl_polls = 1; sl_err_addr = MulB + 32'h8;
    do_req(1'b1, 4'd2, 32'd5, 32'd9);
    wait_rsp(c);
    check_eq("t4_rsp_cycle", 32'(c), 32'd8);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t4_hold%0d_valid", i), 32'(rsp_valid), 32'h1);
      check_eq($sformatf("t4_hold%0d_data", i), rsp_data, 32'h0);
      check_eq($sformatf("t4_hold%0d_err", i), 32'(rsp_err), 32'h1);
      check_eq($sformatf("t4_hold%0d_req_ready", i), 32'(req_ready), 32'h0);
      @(negedge HCLK);
    end
    check_eq("t4_n_status", 32'(n_status), 32'd0);
    check_xfers("t4", MulB, 0, 1'b0, 32'd5, 32'd9, 32'h5, 1'b1);
    take_rsp("t4");
    sl_err_addr = 32'hFFFF_FFFF;

    // T5: reset during the OPB data phase, then a fresh request.
    sl_polls = 1; sl_result = 32'd12;
    do_req(1'b1, 4'd0, 32'd3, 32'd4);
    for (int i = 0; i < 10 && (cyc - acc_base) < 4; i++) @(negedge HCLK);
    check_eq("t5_in_opb_data", 32'(log_addr.size()), 32'd2);
    HRESETn  = 1'b0;
    sl_phase = 0;
    @(negedge HCLK);
    check_eq("t5_rst_htrans", 32'(o_HTRANS), 32'h0);
    check_eq("t5_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check_eq("t5_req_ready", 32'(req_ready), 32'h1);
    hits = 0;
    repeat (5) begin
      if (rsp_valid || o_HTRANS != 2'b00) hits++;
      @(negedge HCLK);
    end
    check_eq("t5_no_activity", 32'(hits), 32'h0);
    check_eq("t5_dropped_xfers", 32'(log_addr.size()), 32'd2);
    sl_result = 32'd72;
    do_req(1'b1, 4'd0, 32'd9, 32'd8);
    wait_rsp(c);
    check_eq("t5_rsp_cycle", 32'(c), 32'd11);
    check_eq("t5_rsp_data", rsp_data, 32'd72);
    check_eq("t5_rsp_err", 32'(rsp_err), 32'h0);
    check_xfers("t5", MulB, 1, 1'b1, 32'd9, 32'd8, 32'h1, 1'b1);
    take_rsp("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
